mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_pkg.sv | 14 +
 rtl/mux4_rr_arbiter_mux4.sv | 24 ++
 rtl/mux4_rr_arbiter.sv | 158 +++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and types for the four-way round-robin mux arbiter.
// Optional grant statistics are enabled by defining MUX4_RR_ARBITER_STATS_EN.
package mux4_arb_pkg;

    localparam int NUM_REQ     = 4;
    localparam int SEL_W       = 2;
    localparam int STATS_CNT_W = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Plain 4:1 data mux shared by the four requesters; no storage.
module mux4_rr_arbiter_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    input  logic [WIDTH-1:0] d3_i,
    output logic [WIDTH-1:0] y_o
);

    // Select one requester word.
    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0:    y_o = d0_i;
            2'd1:    y_o = d1_i;
            2'd2:    y_o = d2_i;
            default: y_o = d3_i;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 data mux with valid/ready output.
// Define MUX4_RR_ARBITER_STATS_EN to add per-requester saturating grant counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no grant; valid_o=0, waiting for any request
// ST_GRANT | grant_o/sel_o frozen, valid_o=1 until the sink takes the word
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3:0]         req_i,
    input  logic [WIDTH-1:0]   d0_i,
    input  logic [WIDTH-1:0]   d1_i,
    input  logic [WIDTH-1:0]   d2_i,
    input  logic [WIDTH-1:0]   d3_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [1:0]         sel_o,
    output logic [3:0]         grant_o,
    output logic [3:0]         ack_o
`ifdef MUX4_RR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*STATS_CNT_W-1:0] grant_cnt_o
`endif
);

    state_e                   state_q, state_d;
    logic [SEL_W-1:0]         ptr_q, ptr_d;
    logic [SEL_W-1:0]         sel_q, sel_d;
    logic [NUM_REQ-1:0]       grant_q, grant_d;
    logic [SEL_W:0]           pick;

    // First set bit at or after ptr, wrapping 3->0; MSB flags "found".
    function automatic logic [SEL_W:0] rr_search(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + i[SEL_W-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    // Next-state, pointer and grant selection; a transfer re-arbitrates in the same cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        pick    = '0;
        case (state_q)
            ST_IDLE: begin
                pick = rr_search(req_i, ptr_q);
                if (pick[SEL_W]) begin
                    state_d = ST_GRANT;
                    sel_d   = pick[SEL_W-1:0];
                    grant_d = 4'b0001 << pick[SEL_W-1:0];
                end
            end
            ST_GRANT: begin
                if (ready_i) begin
                    // The just-served requester sits out one cycle.
                    ptr_d = sel_q + 2'd1;
                    pick  = rr_search(req_i & ~grant_q, sel_q + 2'd1);
                    if (pick[SEL_W]) begin
                        sel_d   = pick[SEL_W-1:0];
                        grant_d = 4'b0001 << pick[SEL_W-1:0];
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, pointer and grant registers; reset drops any word in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign valid_o = (state_q == ST_GRANT);
    assign sel_o   = sel_q;
    assign grant_o = grant_q;
    assign ack_o   = (valid_o && ready_i) ? grant_q : 4'b0000;

    mux4_rr_arbiter_mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .sel_i (sel_q),
        .d0_i  (d0_i),
        .d1_i  (d1_i),
        .d2_i  (d2_i),
        .d3_i  (d3_i),
        .y_o   (data_o)
    );

`ifdef MUX4_RR_ARBITER_STATS_EN
    logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];
    logic [STATS_CNT_W-1:0] cnt_d [NUM_REQ];

    // Count acknowledged transfers per requester, holding at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ack_o[i] && (cnt_q[i] != {STATS_CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Counter registers, cleared with the rest of the arbiter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_pack
        assign grant_cnt_o[g*STATS_CNT_W +: STATS_CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter.
module tb_mux4_rr_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req_i;
    logic [7:0] d0_i, d1_i, d2_i, d3_i;
    logic       ready_i;
    logic       valid_o;
    logic [7:0] data_o;
    logic [1:0] sel_o;
    logic [3:0] grant_o;
    logic [3:0] ack_o;
`ifdef MUX4_RR_ARBITER_STATS_EN
    logic [63:0] grant_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] dexp [4];

    always #5 clk_i = ~clk_i;

    mux4_rr_arbiter #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .d0_i    (d0_i),
        .d1_i    (d1_i),
        .d2_i    (d2_i),
        .d3_i    (d3_i),
        .ready_i (ready_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .sel_o   (sel_o),
        .grant_o (grant_o),
        .ack_o   (ack_o)
`ifdef MUX4_RR_ARBITER_STATS_EN
        ,
        .grant_cnt_o (grant_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        req_i   = 4'b0000;
        ready_i = 1'b0;
        d0_i    = 8'hA0;
        d1_i    = 8'hB1;
        d2_i    = 8'hC2;
        d3_i    = 8'hD3;
        dexp[0] = 8'hA0;
        dexp[1] = 8'hB1;
        dexp[2] = 8'hC2;
        dexp[3] = 8'hD3;

        // reset state
        repeat (2) @(negedge clk_i);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_sel",   64'(sel_o),   64'd0);
        chk("rst_ack",   64'(ack_o),   64'd0);
        rst_i = 1'b0;

        // two requesters, each drops its request after its ack
        req_i = 4'b0101; ready_i = 1'b1;
        @(negedge clk_i);
        chk("t1_grant0", 64'(grant_o), 64'b0001);
        chk("t1_ack0",   64'(ack_o),   64'b0001);
        chk("t1_data0",  64'(data_o),  64'hA0);
        req_i = 4'b0100;
        @(negedge clk_i);
        chk("t1_grant2", 64'(grant_o), 64'b0100);
        chk("t1_sel2",   64'(sel_o),   64'd2);
        chk("t1_ack2",   64'(ack_o),   64'b0100);
        chk("t1_data2",  64'(data_o),  64'hC2);
        req_i = 4'b0000;
        @(negedge clk_i);
        chk("t1_idle_valid", 64'(valid_o), 64'd0);
        chk("t1_idle_grant", 64'(grant_o), 64'd0);

        // all four requesting: strict rotation, back-to-back
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 4'b1111; ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk("t2_sel",   64'(sel_o),   64'(k % 4));
            chk("t2_grant", 64'(grant_o), 64'(4'b0001 << (k % 4)));
            chk("t2_ack",   64'(ack_o),   64'(4'b0001 << (k % 4)));
            chk("t2_valid", 64'(valid_o), 64'd1);
            chk("t2_data",  64'(data_o),  64'(dexp[k % 4]));
        end
        req_i = 4'b0000;
        @(negedge clk_i);
        chk("t2_idle_valid", 64'(valid_o), 64'd0);
`ifdef MUX4_RR_ARBITER_STATS_EN
        chk("t2_stats", grant_cnt_o, {16'd2, 16'd2, 16'd2, 16'd2});
`endif

        // sink stalls: grant frozen, single ack on first ready cycle
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 4'b0010; ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            chk("t3_valid_hold", 64'(valid_o), 64'd1);
            chk("t3_sel_hold",   64'(sel_o),   64'd1);
            chk("t3_ack_none",   64'(ack_o),   64'd0);
        end
        ready_i = 1'b1;
        #1;
        chk("t3_ack", 64'(ack_o), 64'b0010);
        chk("t3_data", 64'(data_o), 64'hB1);
        req_i = 4'b0000;
        @(negedge clk_i);
        chk("t3_after_valid", 64'(valid_o), 64'd0);
        chk("t3_after_ack",   64'(ack_o),   64'd0);

        // lone requester: one word every two cycles
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 4'b1000; ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            chk("t4_valid", 64'(valid_o), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("t4_ack",   64'(ack_o),   (k % 2 == 0) ? 64'b1000 : 64'd0);
        end
        req_i = 4'b0000;

        // async reset mid-grant clears outputs and the priority pointer
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        req_i = 4'b1111; ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t5_pre_sel", 64'(sel_o), 64'd2);
        ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(valid_o), 64'd0);
        chk("t5_rst_grant", 64'(grant_o), 64'd0);
        chk("t5_rst_sel",   64'(sel_o),   64'd0);
        chk("t5_rst_ack",   64'(ack_o),   64'd0);
        rst_i = 1'b0;
        req_i = 4'b1001; ready_i = 1'b1;
        @(negedge clk_i);
        chk("t5_ptr0_grant", 64'(grant_o), 64'b0001);
        chk("t5_ptr0_sel",   64'(sel_o),   64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
